pci_target_mem: RTL
===================

Name: pci_target_mem

Overview:
- Memory-backed PCI bus target that sits directly downstream of the Controller initiators on the shared d / C_BE / frame / irdy / trdy / devsel bus.
- Decodes the address phase and claims transactions addressed to its DEV_ID.
- Accepts single or burst writes with byte enables, and returns burst read data from an internal word array.
- Gives the initiator testbenches a real responder in place of the floating trdy/devsel wires.

Parameters:
DEV_ID, 2'b00, device address this target answers to (compared with d[1:0] in the address phase)
DEPTH, 16, number of 32-bit words stored (power of two)
IDX_W, 4, log2(DEPTH); width of the word pointer

Ports:
clk  input  1  bus clock; all sampling on the rising edge
reset_add_n  input  1  asynchronous, active-low reset
d  inout  32  shared address/data bus; the target drives it only in read data phases
C_BE  input  4  command in the address phase, byte enables in data phases (1 = lane enabled)
frame  input  1  active-low; asserted by the initiator for the whole transaction, deasserted at the final data phase
irdy  input  1  active-low initiator ready
trdy  output  1  active-low target ready; 1'bz when not claimed
devsel  output  1  active-low device select; 1'bz when not claimed
busy  output  1  high while the FSM is not in IDLE (debug/visibility)

Behaviour:
- Reset (asynchronous, any state): FSM to IDLE; trdy, devsel and d go to 1'bz; busy=0; word pointer=0; all memory words = 0.
- Commands sampled from C_BE in the address phase: 4'b0110 = MEM_READ, 4'b0111 = MEM_WRITE. Any other code is ignored, with no devsel.
- Address phase: first rising edge with frame=0 while in IDLE and frame was 1 on the previous edge. Hit when d[1:0]==DEV_ID and the command is valid.
- Word pointer: loaded from d[IDX_W+1:2] in the address phase. Increments after each completed data phase and wraps DEPTH-1 -> 0.
- A data phase completes on a rising edge with irdy=0 and trdy=0.
- States:
  - IDLE: on a write hit -> WR_DATA; on a read hit -> RD_TURN; on a miss, stays in IDLE until frame=1.
  - WR_DATA: devsel=0, trdy=0 from the cycle after the address phase (zero wait states). Each completed phase writes the enabled byte lanes of d to mem[ptr]. If frame=1 at the completing edge -> BACKOFF.
  - RD_TURN: one turnaround cycle; devsel=0, trdy=1, d=z. Then -> RD_DATA.
  - RD_DATA: devsel=0, trdy=0, d=mem[ptr]. Byte enables are ignored on reads (the full word is driven). The pointer advances on each completion; the next word is driven in the following cycle. If frame=1 at a completion -> BACKOFF.
  - BACKOFF: drive trdy=1, devsel=1, d=z for one cycle, then release to z -> IDLE.
- irdy=1 in a data phase: the target holds its state, pointer and driven data; nothing is written.
- frame already 1 at the first data phase: single-word transfer.
- A new frame falling edge while not in IDLE is ignored; a claimed transaction always completes first.
- Reset asserted mid-burst: the bus is released in the same cycle (asynchronous); a partial write keeps the words already completed and the memory is then cleared by reset.

Optional Feature:
TARGET_WAIT_EN
- Defined: one trdy wait state is inserted before the first data phase of every claimed transaction (trdy=1 for one extra cycle while devsel=0), so reads see latency 3 from the address phase.
- Undefined: zero wait states, as described above.
- Read latency without the macro: address phase edge -> turnaround -> data driven on the 2nd cycle after the address phase.

Decomposition:
- Package pci_pkg holds: command constants CMD_MEM_READ and CMD_MEM_WRITE, and the FSM state encoding (IDLE, WR_DATA, RD_TURN, RD_DATA, BACKOFF).
- One sub-module, pci_target_regfile: a DEPTH x 32 array with asynchronous clear, a byte-enabled synchronous write port and a combinational read port.

Test Plan:
- Write burst to DEV_ID, pointer 0, data AAAA0000..AAAA0003, C_BE=1111, frame released on the 4th phase -> mem[0..3] hold those values; devsel=0 for 4 cycles, then BACKOFF, then z.
- Read burst of 4 from pointer 0 after the write above -> one turnaround cycle, then d = AAAA0000..AAAA0003 on successive completing edges.
- Address with d[1:0] != DEV_ID, or command 4'b0010 -> devsel and trdy stay z for the whole transaction; memory unchanged.
- Single write of FFFFFFFF with C_BE=0101 to a word holding 12345678 -> readback gives 12FF56FF. Then a 3-word write starting at pointer 15 -> words 15, 0, 1 written (wrap).
- irdy held at 1 for 2 cycles mid-read -> the same word stays on d and the pointer does not advance; reset_add_n pulsed low mid-burst -> trdy, devsel and d go to z immediately and memory reads 0 afterwards.
- With TARGET_WAIT_EN defined, a single write -> trdy falls one cycle later than without the macro; the data is still stored correctly.

Source files
------------

// File: rtl/pci_pkg.sv
// Shared command codes and FSM state encoding for the memory-backed PCI target.
package pci_pkg;

  localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DATA = 3'd1,
    RD_TURN = 3'd2,
    RD_DATA = 3'd3,
    BACKOFF = 3'd4
  } state_t;

endpackage

// File: rtl/pci_target_regfile.sv
// DEPTH x 32 word store: asynchronous clear, byte-enabled synchronous write,
// combinational read so the target can drive the addressed word in the same cycle.
module pci_target_regfile #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [3:0]       i_be,
  input  logic [31:0]      i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pci_target_mem.sv
// Memory-backed PCI target: claims MEM_READ/MEM_WRITE bursts addressed to DEV_ID.
// Define TARGET_WAIT_EN to insert one trdy wait state before the first data phase.
module pci_target_mem
  import pci_pkg::*;
#(
  parameter logic [1:0] DEV_ID = 2'b00,
  parameter int         DEPTH  = 16,
  parameter int         IDX_W  = 4
) (
  input  logic        clk,
  input  logic        reset_add_n,
  inout  wire  [31:0] d,
  input  logic [3:0]  C_BE,
  input  logic        frame,
  input  logic        irdy,
  output wire         trdy,
  output wire         devsel,
  output logic        busy
);

`ifdef TARGET_WAIT_EN
  localparam logic WAIT_INIT = 1'b1;
`else
  localparam logic WAIT_INIT = 1'b0;
`endif

  state_t           r_state, w_state_next;
  logic             r_frame_prev;
  logic [IDX_W-1:0] r_ptr;
  logic             r_wait;
  logic             w_addr_phase, w_is_rd, w_is_wr, w_hit, w_done;
  logic             w_trdy, w_devsel, w_claim, w_drive;
  logic [31:0]      w_rdata;

  // An address phase needs a genuine frame falling edge seen from IDLE.
  assign w_addr_phase = (r_state == IDLE) && !frame && r_frame_prev;
  assign w_is_rd      = (C_BE == CMD_MEM_READ);
  assign w_is_wr      = (C_BE == CMD_MEM_WRITE);
  assign w_hit        = w_addr_phase && (d[1:0] == DEV_ID) && (w_is_rd || w_is_wr);
  assign w_done       = !irdy && !w_trdy;

  always_comb begin
    w_state_next = r_state;
    w_trdy       = 1'b1;
    w_devsel     = 1'b1;
    w_claim      = 1'b0;
    w_drive      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hit) w_state_next = w_is_wr ? WR_DATA : RD_TURN;
      end
      WR_DATA: begin
        w_claim  = 1'b1;
        w_devsel = 1'b0;
        w_trdy   = r_wait;
        if (!irdy && !r_wait && frame) w_state_next = BACKOFF;
      end
      RD_TURN: begin
        w_claim      = 1'b1;
        w_devsel     = 1'b0;
        w_state_next = RD_DATA;
      end
      RD_DATA: begin
        w_claim  = 1'b1;
        w_devsel = 1'b0;
        w_trdy   = r_wait;
        w_drive  = 1'b1;
        if (!irdy && !r_wait && frame) w_state_next = BACKOFF;
      end
      BACKOFF: begin
        w_claim      = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_add_n) begin
    if (!reset_add_n) begin
      r_state      <= IDLE;
      r_frame_prev <= 1'b0;
      r_ptr        <= '0;
      r_wait       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_frame_prev <= frame;
      if (w_hit) begin
        r_ptr  <= d[IDX_W+1:2];
        r_wait <= WAIT_INIT;
      end else begin
        if (w_done) r_ptr <= r_ptr + IDX_W'(1);
        if (r_state == WR_DATA || r_state == RD_DATA) r_wait <= 1'b0;
      end
    end
  end

  pci_target_regfile #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_regfile (
    .clk     (clk),
    .i_rst_n (reset_add_n),
    .i_we    (w_done && (r_state == WR_DATA)),
    .i_waddr (r_ptr),
    .i_be    (C_BE),
    .i_wdata (d),
    .i_raddr (r_ptr),
    .o_rdata (w_rdata)
  );

  // Releasing these combinationally from state lets an async reset free the bus at once.
  assign trdy   = w_claim ? w_trdy   : 1'bz;
  assign devsel = w_claim ? w_devsel : 1'bz;
  assign d      = w_drive ? w_rdata  : 32'bz;
  assign busy   = (r_state != IDLE);

endmodule
